// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with transmit FIFO, runtime frame format and baud divisor
module uart_tx_fifo #(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [7:0]           wr_data,
    input  logic [DIV_WIDTH-1:0] cfg_div,
    input  logic [1:0]           cfg_bits,
    input  logic [1:0]           cfg_parity,
    input  logic                 cfg_stop2,
    output logic                 tx_out,
    output logic                 tx_busy,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] fifo_count,
    output logic                 overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [7:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic                 push, pop;
    logic [CNT_WIDTH-1:0] count_nx;
    logic [7:0]           head, head_mask;

    logic [7:0]           data_l;
    logic [DIV_WIDTH-1:0] div_l;
    logic [1:0]           bits_l;
    logic                 par_en_l, par_bit_l, stop2_l;
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic [2:0]           bit_idx;
    logic                 stop_idx;
    logic                 bit_done, last_data, last_stop, tx_nx;

    assign push      = wr_en && !full;
    assign head      = mem[rd_ptr];
    assign bit_done  = (baud_cnt == div_l);
    assign last_data = (bit_idx == 3'd4 + {1'b0, bits_l});
    assign last_stop = (stop_idx == stop2_l);
    assign count_nx  = fifo_count + CNT_WIDTH'(push) - CNT_WIDTH'(pop);

    always_comb begin
        case (cfg_bits)
            2'b00:   head_mask = 8'h1f;
            2'b01:   head_mask = 8'h3f;
            2'b10:   head_mask = 8'h7f;
            default: head_mask = 8'hff;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // The FIFO is popped exactly when a new frame is entered, from IDLE or straight out of the last stop bit.
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                state_nx = START;
                pop      = 1'b1;
            end
            START:  if (bit_done) state_nx = DATA;
            DATA:   if (bit_done && last_data) state_nx = par_en_l ? PARITY : STOP;
            PARITY: if (bit_done) state_nx = STOP;
            STOP: if (bit_done && last_stop) begin
                if (!empty) begin
                    state_nx = START;
                    pop      = 1'b1;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        tx_nx = 1'b1;
        case (state)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = data_l[bit_idx];
            PARITY:  tx_nx = par_bit_l;
            default: tx_nx = 1'b1;
        endcase
    end

    // tx_out trails the state by one edge, so the start bit appears two edges after a write into an idle FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_out    <= 1'b1;
            tx_busy   <= 1'b0;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            data_l    <= '0;
            div_l     <= '0;
            bits_l    <= '0;
            par_en_l  <= 1'b0;
            par_bit_l <= 1'b0;
            stop2_l   <= 1'b0;
        end else begin
            tx_out  <= tx_nx;
            tx_busy <= (state != IDLE) || !empty;
            if (state == IDLE || bit_done) baud_cnt <= '0;
            else                           baud_cnt <= baud_cnt + 1'b1;
            if (state != DATA)  bit_idx <= '0;
            else if (bit_done)  bit_idx <= bit_idx + 1'b1;
            if (state != STOP)  stop_idx <= 1'b0;
            else if (bit_done)  stop_idx <= ~stop_idx;
            if (pop) begin
                data_l    <= head;
                div_l     <= cfg_div;
                bits_l    <= cfg_bits;
                par_en_l  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                par_bit_l <= (^(head & head_mask)) ^ (cfg_parity == 2'b10);
                stop2_l   <= cfg_stop2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= count_nx;
            full       <= (count_nx == CNT_WIDTH'(FIFO_DEPTH));
            empty      <= (count_nx == '0);
            if (wr_en && full) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - randomized self-checking bench for uart_tx_fifo against a frame-level line model
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_bits;
    logic [1:0]  cfg_parity;
    logic        cfg_stop2;
    logic        tx_out, tx_busy, full, empty, overflow;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    bit         exp_q[$];
    bit         tx_q[$], busy_q[$], full_q[$], ovf_q[$];
    int         cnt_q[$];
    logic [7:0] wq[$];
    int         wt[$];
    int         chg_cyc = -1;
    int         chg_div = 0;

    uart_tx_fifo #(.DIV_WIDTH(16), .FIFO_DEPTH(4), .CNT_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .cfg_div(cfg_div), .cfg_bits(cfg_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
        .tx_out(tx_out), .tx_busy(tx_busy), .full(full), .empty(empty),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Line model: a frame is a list of levels, each held for div+1 cycles.
    task automatic add_frame(input logic [7:0] d, input int nb, input int par, input bit s2, input int div);
        bit lv[$];
        bit p;
        p = 1'b0;
        lv.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            lv.push_back(d[i]);
            p ^= d[i];
        end
        if (par == 1) lv.push_back(p);
        else if (par == 2) lv.push_back(!p);
        lv.push_back(1'b1);
        if (s2) lv.push_back(1'b1);
        foreach (lv[i]) repeat (div + 1) exp_q.push_back(lv[i]);
    endtask

    task automatic set_cfg(input int div, input int bits, input int par, input bit s2);
        cfg_div    = 16'(div);
        cfg_bits   = 2'(bits);
        cfg_parity = 2'(par);
        cfg_stop2  = s2;
    endtask

    task automatic clear_all;
        exp_q.delete();
        wq.delete();
        wt.delete();
    endtask

    // Plays the write schedule (wq at cycles wt) and records outputs after every edge; no checking here.
    task automatic capture(input int ncyc);
        tx_q.delete(); busy_q.delete(); full_q.delete(); ovf_q.delete(); cnt_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            wr_en = 1'b0;
            foreach (wt[i]) if (wt[i] == c) begin
                wr_en   = 1'b1;
                wr_data = wq[i];
            end
            if (c == chg_cyc) cfg_div = 16'(chg_div);
            tick;
            tx_q.push_back(tx_out);
            busy_q.push_back(tx_busy);
            full_q.push_back(full);
            ovf_q.push_back(overflow);
            cnt_q.push_back(int'(fifo_count));
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0; wr_en = 1'b1; wr_data = 8'hff;
        set_cfg(3, 3, 0, 0);
        tick; tick;
        checks++;
        if ({tx_out, tx_busy} !== 2'b10) begin
            errors++; $display("FAIL reset_line tx_out/tx_busy %b required 10", {tx_out, tx_busy});
        end
        checks++;
        if ({empty, full, overflow} !== 3'b100) begin
            errors++; $display("FAIL reset_flags empty/full/overflow %b required 100", {empty, full, overflow});
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++; $display("FAIL reset_count %0d required 0", fifo_count);
        end
        reset = 1'b1; wr_en = 1'b0;
        tick;
    endtask

    task automatic test_8n1;
        int mism, len;
        clear_all();
        set_cfg(3, 3, 0, 0);
        wq.push_back(8'h55); wt.push_back(0);
        add_frame(8'h55, 8, 0, 0, 3);
        len = exp_q.size();
        capture(len + 3);
        checks++;
        if (tx_q[1] !== 1'b1) begin
            errors++; $display("FAIL 8n1_start_latency tx_out after edge k+1 %b required 1", tx_q[1]);
        end
        mism = -1;
        foreach (exp_q[j]) if (mism < 0 && tx_q[2 + j] !== exp_q[j]) mism = j;
        checks++;
        if (mism >= 0) begin
            errors++; $display("FAIL 8n1_wave cycle %0d tx_out %b required %b", mism, tx_q[2 + mism], exp_q[mism]);
        end
        checks++;
        if (busy_q[len + 1] !== 1'b1 || busy_q[len + 2] !== 1'b0) begin
            errors++; $display("FAIL 8n1_busy_fall got %b%b required 10", busy_q[len + 1], busy_q[len + 2]);
        end
    endtask

    task automatic test_parity;
        int mism, len;
        for (int par = 1; par <= 2; par++) begin
            clear_all();
            set_cfg(1, 2, par, 1);
            wq.push_back(8'h03); wt.push_back(0);
            add_frame(8'h03, 7, par, 1, 1);
            len = exp_q.size();
            capture(len + 3);
            mism = -1;
            foreach (exp_q[j]) if (mism < 0 && tx_q[2 + j] !== exp_q[j]) mism = j;
            checks++;
            if (mism >= 0) begin
                errors++; $display("FAIL parity%0d_wave cycle %0d tx_out %b required %b", par, mism, tx_q[2 + mism], exp_q[mism]);
            end
            checks++;
            if (busy_q[len + 2] !== 1'b0) begin
                errors++; $display("FAIL parity%0d_busy_end tx_busy %b required 0", par, busy_q[len + 2]);
            end
        end
    endtask

    task automatic test_fifo_order;
        int mism, len, flen;
        logic [7:0] x;
        clear_all();
        set_cfg(2, 3, 0, 0);
        x = 8'($urandom);
        wq.push_back(x);     wt.push_back(0);
        wq.push_back(8'hA5); wt.push_back(3);
        wq.push_back(8'h3C); wt.push_back(4);
        add_frame(x, 8, 0, 0, 2);
        flen = exp_q.size();
        add_frame(8'hA5, 8, 0, 0, 2);
        add_frame(8'h3C, 8, 0, 0, 2);
        len = exp_q.size();
        capture(len + 3);
        checks++;
        if (cnt_q[3] !== 1 || cnt_q[4] !== 2) begin
            errors++; $display("FAIL order_count_rise got %0d,%0d required 1,2", cnt_q[3], cnt_q[4]);
        end
        checks++;
        if (cnt_q[flen] !== 2 || cnt_q[flen + 1] !== 1) begin
            errors++; $display("FAIL order_count_pop got %0d,%0d required 2,1", cnt_q[flen], cnt_q[flen + 1]);
        end
        checks++;
        if (cnt_q[len + 2] !== 0) begin
            errors++; $display("FAIL order_count_end got %0d required 0", cnt_q[len + 2]);
        end
        mism = -1;
        foreach (exp_q[j]) if (mism < 0 && tx_q[2 + j] !== exp_q[j]) mism = j;
        checks++;
        if (mism >= 0) begin
            errors++; $display("FAIL order_wave cycle %0d tx_out %b required %b", mism, tx_q[2 + mism], exp_q[mism]);
        end
    endtask

    task automatic test_cfg_change;
        int mism, len;
        logic [7:0] d0, d1;
        clear_all();
        set_cfg(3, 3, 0, 0);
        d0 = 8'($urandom); d1 = 8'($urandom);
        wq.push_back(d0); wt.push_back(0);
        wq.push_back(d1); wt.push_back(1);
        add_frame(d0, 8, 0, 0, 3);
        add_frame(d1, 8, 0, 0, 7);
        len = exp_q.size();
        chg_cyc = 10; chg_div = 7;
        capture(len + 3);
        chg_cyc = -1;
        checks++;
        if (cnt_q[1] !== 1) begin
            errors++; $display("FAIL cfgchg_push_pop_count got %0d required 1", cnt_q[1]);
        end
        mism = -1;
        foreach (exp_q[j]) if (mism < 0 && tx_q[2 + j] !== exp_q[j]) mism = j;
        checks++;
        if (mism >= 0) begin
            errors++; $display("FAIL cfgchg_wave cycle %0d tx_out %b required %b", mism, tx_q[2 + mism], exp_q[mism]);
        end
    endtask

    task automatic test_random;
        int mism, len, n, div, bits, par;
        bit s2;
        logic [7:0] d;
        for (int it = 0; it < 8; it++) begin
            clear_all();
            div  = int'($urandom_range(0, 3));
            bits = int'($urandom_range(0, 3));
            par  = int'($urandom_range(0, 3));
            s2   = 1'($urandom);
            n    = int'($urandom_range(1, 3));
            set_cfg(div, bits, par, s2);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                wq.push_back(d); wt.push_back(i);
                add_frame(d, bits + 5, (par == 3) ? 0 : par, s2, div);
            end
            len = exp_q.size();
            capture(len + 3);
            mism = -1;
            foreach (exp_q[j]) if (mism < 0 && tx_q[2 + j] !== exp_q[j]) mism = j;
            checks++;
            if (mism >= 0) begin
                errors++; $display("FAIL random%0d_wave div %0d bits %0d par %0d s2 %0d cycle %0d tx_out %b required %b",
                                   it, div, bits, par, s2, mism, tx_q[2 + mism], exp_q[mism]);
            end
            checks++;
            if (busy_q[len + 1] !== 1'b1 || busy_q[len + 2] !== 1'b0) begin
                errors++; $display("FAIL random%0d_busy got %b%b required 10", it, busy_q[len + 1], busy_q[len + 2]);
            end
        end
    endtask

    task automatic test_overflow;
        int mism, len;
        logic [7:0] d;
        clear_all();
        set_cfg(1, 3, 0, 0);
        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom);
            wq.push_back(d);
            wt.push_back((i == 0) ? 0 : i + 1);
            if (i < 5) add_frame(d, 8, 0, 0, 1);
        end
        len = exp_q.size();
        capture(len + 3);
        checks++;
        if (full_q[4] !== 1'b0 || cnt_q[4] !== 3) begin
            errors++; $display("FAIL ovf_before_full full %b count %0d required 0,3", full_q[4], cnt_q[4]);
        end
        checks++;
        if (full_q[5] !== 1'b1 || cnt_q[5] !== 4 || ovf_q[5] !== 1'b0) begin
            errors++; $display("FAIL ovf_full full %b count %0d overflow %b required 1,4,0", full_q[5], cnt_q[5], ovf_q[5]);
        end
        checks++;
        if (ovf_q[6] !== 1'b1 || cnt_q[6] !== 4) begin
            errors++; $display("FAIL ovf_dropped overflow %b count %0d required 1,4", ovf_q[6], cnt_q[6]);
        end
        mism = -1;
        foreach (exp_q[j]) if (mism < 0 && tx_q[2 + j] !== exp_q[j]) mism = j;
        checks++;
        if (mism >= 0) begin
            errors++; $display("FAIL ovf_wave cycle %0d tx_out %b required %b", mism, tx_q[2 + mism], exp_q[mism]);
        end
        checks++;
        if (ovf_q[len + 2] !== 1'b1) begin
            errors++; $display("FAIL ovf_sticky overflow %b required 1", ovf_q[len + 2]);
        end
    endtask

    task automatic test_reset_mid;
        bit saw_low;
        set_cfg(3, 3, 0, 0);
        for (int c = 0; c < 12; c++) begin
            wr_en   = (c < 3);
            wr_data = 8'($urandom);
            tick;
        end
        wr_en = 1'b0;
        checks++;
        if (tx_busy !== 1'b1 || overflow !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre busy %b overflow %b required 1,1", tx_busy, overflow);
        end
        reset = 1'b0; wr_en = 1'b1; wr_data = 8'h00;
        tick;
        checks++;
        if (tx_out !== 1'b1 || fifo_count !== 3'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL rstmid_abort tx_out %b count %0d overflow %b required 1,0,0", tx_out, fifo_count, overflow);
        end
        tick;
        reset = 1'b1; wr_en = 1'b0;
        tick;
        checks++;
        if (empty !== 1'b1 || fifo_count !== 3'd0 || tx_busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_wr_ignored empty %b count %0d busy %b required 1,0,0", empty, fifo_count, tx_busy);
        end
        saw_low = 1'b0;
        repeat (6) begin
            tick;
            if (tx_out !== 1'b1) saw_low = 1'b1;
        end
        checks++;
        if (saw_low) begin
            errors++; $display("FAIL rstmid_idle_line tx_out went low 1 required 0");
        end
    endtask

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_data = '0;
        set_cfg(0, 3, 0, 0);
        test_reset();
        test_8n1();
        test_parity();
        test_fifo_order();
        test_cfg_change();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 16, width of the baud divisor input.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, transmit FIFO entries; a power of two, 2..256.
REQ-003 SHALL have parameter CNT_WIDTH, default 5, width of fifo_count; equals log2(FIFO_DEPTH)+1.
REQ-004 SHALL have port clk  input  1  the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-low; sampled on the clk rising edge.
REQ-006 SHALL have port wr_en  input  1  push wr_data into the FIFO.
REQ-007 SHALL have port wr_data  input  8  character to send, LSB first; bits above the configured length are ignored.
REQ-008 SHALL have port cfg_div  input  DIV_WIDTH  bit period minus one, in clk cycles.
REQ-009 SHALL have port cfg_bits  input  2  data length: 00=5, 01=6, 10=7, 11=8.
REQ-010 SHALL have port cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none.
REQ-011 SHALL have port cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-012 SHALL have port tx_out  output  1  serial line, idle high.
REQ-013 SHALL have port tx_busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-014 SHALL have port full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-015 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-016 SHALL have port fifo_count  output  CNT_WIDTH  current FIFO occupancy.
REQ-017 SHALL have port overflow  output  1  sticky flag: a write was attempted while full.

Function
REQ-018 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-019 SHALL hold every bit, including each stop bit, for exactly cfg_div+1 clk cycles; cfg_div=0 gives a 1-cycle bit.
REQ-020 SHALL, in IDLE with the FIFO non-empty, pop the head entry, latch it together with cfg_div/cfg_bits/cfg_parity/cfg_stop2, and enter START; config changes mid-frame have no effect on that frame.
REQ-021 SHALL drive tx_out low from the second rising edge after a write into an empty FIFO while IDLE (write at edge k, start bit from edge k+2).
REQ-022 SHALL send data bits LSB first, 5..8 per the latched cfg_bits, then go to PARITY if parity is enabled, else to STOP.
REQ-023 SHALL send parity as the XOR of the sent data bits for even, and its inverse for odd.
REQ-024 SHALL send one or two high stop bit periods per cfg_stop2.
REQ-025 SHALL, at the end of the last stop bit with the FIFO non-empty, go straight to START with no idle gap; otherwise go to IDLE.
REQ-026 SHALL accept wr_en only when full=0; a write while full is dropped and sets overflow, even if a pop occurs in the same cycle.
REQ-027 SHALL, on a simultaneous accepted write and pop, leave fifo_count unchanged and preserve FIFO order.
REQ-028 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-029 SHALL treat any unreachable FSM state as IDLE on the next edge, with tx_out=1.

Reset
REQ-030 SHALL, while reset=0 at a clk edge, set state IDLE, tx_out=1, tx_busy=0, empty=1, full=0, fifo_count=0, overflow=0, and discard FIFO contents.
REQ-031 SHALL abort a frame on reset mid-frame, driving tx_out=1 from the next edge with no partial stop bit.
REQ-032 SHALL ignore wr_en in any cycle where reset=0.

Verification
REQ-033 cfg_div=3, 8N1, write 0x55 -> 40 cycles: low 4, then 1,0,1,0,1,0,1,0 each 4 cycles, then high 4; tx_busy falls after the stop bit.
REQ-034 cfg_div=1, 7E2, write 0x03 -> start, 1,1,0,0,0,0,0, parity 0, two stop bits; 11 bits x 2 cycles; odd parity instead gives parity 1.
REQ-035 FIFO_DEPTH=4, 5 writes with no pop -> full=1 after the 4th write; the 5th is dropped and sets overflow; 4 frames go back to back with no gap.
REQ-036 Write 0xA5 and 0x3C while busy -> frames in order; fifo_count goes 0->1->2 then drops on each pop.
REQ-037 Change cfg_div from 3 to 7 mid-frame -> current frame keeps a 4-cycle bit period; next frame uses 8 cycles.
REQ-038 Reset low in the DATA state -> next edge gives tx_out=1, fifo_count=0, overflow=0; wr_en during reset is ignored.
